// File: rtl/reg_mem_pkg.sv
//------------------------------------------------------------------------------
// Module : reg_mem_pkg
// Brief  : Shared FSM state type and even-parity helper for reg_mem.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package reg_mem_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_e;

  // Widest word the parity helper accepts; narrower words are zero-extended.
  localparam int PAR_MAX_W = 64;

  function automatic logic par_even(input logic [PAR_MAX_W-1:0] word);
    return ^word;
  endfunction

endpackage

`default_nettype wire

// File: rtl/reg_mem_if.sv
//------------------------------------------------------------------------------
// Module : reg_mem_if
// Brief  : Write/read/fill bus of reg_mem; master drives requests, slave answers.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface reg_mem_if #(
  parameter int WIDTH = 8,
  parameter int AW    = 6
);

  logic             we;
  logic [AW-1:0]    wadd;
  logic [WIDTH-1:0] Din;
  logic             re;
  logic [AW-1:0]    radd;
  logic [WIDTH-1:0] Dout;
  logic             rvalid;
  logic             init_req;
  logic [WIDTH-1:0] init_val;
  logic             busy;
  logic             wr_drop;
  logic             perr;

  modport master (
    output we, wadd, Din, re, radd, init_req, init_val,
    input  Dout, rvalid, busy, wr_drop, perr
  );

  modport slave (
    input  we, wadd, Din, re, radd, init_req, init_val,
    output Dout, rvalid, busy, wr_drop, perr
  );

endinterface

`default_nettype wire

// File: rtl/reg_word.sv
//------------------------------------------------------------------------------
// Module : reg_word
// Brief  : One storage word with asynchronous active-high clear and write enable.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module reg_word #(
  parameter int W = 8
) (
  input  wire logic         clk,
  input  wire logic         clr,
  input  wire logic         we,
  input  wire logic [W-1:0] d,
  output logic      [W-1:0] q
);

  logic [W-1:0] word_q;
  logic [W-1:0] word_d;

  always_comb begin
    word_d = we ? d : word_q;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      word_q <= '0;
    end else begin
      word_q <= word_d;
    end
  end

  assign q = word_q;

endmodule

`default_nettype wire

// File: rtl/reg_mem.sv
//------------------------------------------------------------------------------
// Module : reg_mem
// Brief  : DEPTH x WIDTH flop register file with registered read port and a
//          sequential bulk-fill engine. Define REG_MEM_PARITY_EN for per-word
//          even parity with a read-time perr pulse.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module reg_mem
  import reg_mem_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64
) (
  input  wire logic clk,
  input  wire logic Cl,
  reg_mem_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
`ifdef REG_MEM_PARITY_EN
  localparam int PW = 1;
`else
  localparam int PW = 0;
`endif
  localparam int WW = WIDTH + PW;

  state_e           state_q, state_d;
  logic [AW-1:0]    ptr_q, ptr_d;
  logic [WIDTH-1:0] fill_val_q, fill_val_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             rvalid_q, rvalid_d;
  logic             wr_drop_q, wr_drop_d;
  logic             perr_q, perr_d;

  logic             fill;
  logic [WIDTH-1:0] wr_data;
  logic [WW-1:0]    wr_word;
  logic [WW-1:0]    rd_word;
  logic [DEPTH-1:0] word_we;
  logic [WW-1:0]    words [DEPTH];

  assign fill    = (state_q == ST_FILL);
  assign wr_data = fill ? fill_val_q : bus.Din;

`ifdef REG_MEM_PARITY_EN
  assign wr_word = {par_even(PAR_MAX_W'(wr_data)), wr_data};
`else
  assign wr_word = wr_data;
`endif

  // The fill owns every word while it runs; user writes are locked out.
  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    assign word_we[i] = fill ? (ptr_q == AW'(i))
                             : (bus.we && (bus.wadd == AW'(i)));

    reg_word #(.W(WW)) u_word (
      .clk (clk),
      .clr (Cl),
      .we  (word_we[i]),
      .d   (wr_word),
      .q   (words[i])
    );
  end

  // Addresses with no matching word fall through to zero.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.radd == AW'(i)) rd_word = words[i];
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    fill_val_d = fill_val_q;
    dout_d     = bus.re ? rd_word[WIDTH-1:0] : dout_q;
    rvalid_d   = bus.re;
    wr_drop_d  = fill && bus.we;
    perr_d     = 1'b0;
`ifdef REG_MEM_PARITY_EN
    perr_d     = bus.re && (rd_word[WIDTH] != par_even(PAR_MAX_W'(rd_word[WIDTH-1:0])));
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (bus.init_req) begin
          state_d    = ST_FILL;
          ptr_d      = '0;
          fill_val_d = bus.init_val;
        end
      end
      ST_FILL: begin
        ptr_d = ptr_q + AW'(1);
        if (ptr_q == AW'(DEPTH - 1)) begin
          state_d = ST_IDLE;
          ptr_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge Cl) begin
    if (Cl) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      fill_val_q <= '0;
      dout_q     <= '0;
      rvalid_q   <= 1'b0;
      wr_drop_q  <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      fill_val_q <= fill_val_d;
      dout_q     <= dout_d;
      rvalid_q   <= rvalid_d;
      wr_drop_q  <= wr_drop_d;
      perr_q     <= perr_d;
    end
  end

  assign bus.Dout    = dout_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.busy    = fill;
  assign bus.wr_drop = wr_drop_q;
  assign bus.perr    = perr_q;

endmodule

`default_nettype wire
